// File: rtl/alu_share_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : alu_share_scheduler
// Description : Time-shares one 4-bit ALU (8-function lab encoding) between
//               two requesters, each owning an 8-bit accumulator context.
//               A round-robin arbiter selects the owner. The op is latched at
//               issue, run for EXEC_CYCLES in EXEC, and written back in DONE
//               with a one-cycle registered ack to the owner.
// Ports       : clock            - single clock, all state on posedge
//               reset            - synchronous, active-high
//               req0/func0/data0 - requester 0 level request, function, operand A
//               req1/func1/data1 - requester 1 level request, function, operand A
//               ack0/ack1        - one-cycle completion pulses
//               result0/result1  - last result per requester (held until next ack)
//               acc0/acc1        - per-requester accumulators
//               grant            - one-hot ALU owner, 2'b00 when idle
//               busy             - high in EXEC or DONE
// Revision    : 1.0 - initial release
// ============================================================================
module alu_share_scheduler #(
  parameter int unsigned EXEC_CYCLES = 2,      // 1..15
  parameter logic [7:0]  ACC_RESET   = 8'h00
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       req0,
  input  logic [2:0] func0,
  input  logic [3:0] data0,
  input  logic       req1,
  input  logic [2:0] func1,
  input  logic [3:0] data1,
  output logic       ack0,
  output logic       ack1,
  output logic [7:0] result0,
  output logic [7:0] result1,
  output logic [7:0] acc0,
  output logic [7:0] acc1,
  output logic [1:0] grant,
  output logic       busy
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter is loaded with EXEC_CYCLES-1 so that EXEC lasts exactly EXEC_CYCLES.
  localparam logic [3:0] c_CNT_LOAD = 4'(EXEC_CYCLES - 1);

  state_t     r_state;
  state_t     w_state_next;

  logic [3:0] r_cnt;
  logic       r_owner;
  logic [2:0] r_func;
  logic [3:0] r_data;
  logic [7:0] r_res;
  logic [7:0] r_acc0;
  logic [7:0] r_acc1;
  logic [7:0] r_result0;
  logic [7:0] r_result1;
  logic       r_ack0;
  logic       r_ack1;
  logic [1:0] r_grant;
  logic       r_rr_last;

  logic       w_issue;
  logic       w_winner;
  logic [3:0] w_b;
  logic [7:0] w_alu_res;

  // --------------------------------------------------------------------------
  // Arbitration: a lone requester wins; on a tie the requester that was not
  // served last wins.
  // --------------------------------------------------------------------------
  always_comb begin
    w_issue  = req0 | req1;
    w_winner = 1'b0;
    if (req0 && req1) begin
      w_winner = ~r_rr_last;
    end else if (req1) begin
      w_winner = 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next-state
  // --------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: if (w_issue) w_state_next = ST_EXEC;
      ST_EXEC: if (r_cnt == 4'd0) w_state_next = ST_DONE;
      ST_DONE: w_state_next = ST_IDLE;
      default: w_state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Shared ALU. Operand B always comes from the owner's accumulator.
  // --------------------------------------------------------------------------
  always_comb begin
    w_b       = r_owner ? r_acc1[3:0] : r_acc0[3:0];
    w_alu_res = 8'h00;
    case (r_func)
      3'b000:         w_alu_res = {3'b000, {1'b0, r_data} + 5'd1};
      3'b001, 3'b010: w_alu_res = {3'b000, {1'b0, r_data} + {1'b0, w_b}};
      3'b011:         w_alu_res = {r_data | w_b, r_data ^ w_b};
      3'b100:         w_alu_res = {7'b0, |(r_data | w_b)};
      // Shift amounts of 8 or more clear the whole byte.
      3'b101:         w_alu_res = r_data[3] ? 8'h00 : ({4'b0000, w_b} << r_data[2:0]);
      3'b110:         w_alu_res = {4'b0000, w_b >> r_data};
      3'b111:         w_alu_res = {4'b0000, r_data} * {4'b0000, w_b};
      default:        w_alu_res = 8'h00;
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath registers
  // --------------------------------------------------------------------------
  always_ff @(posedge clock) begin
    if (reset) begin
      r_cnt     <= 4'd0;
      r_owner   <= 1'b0;
      r_func    <= 3'b000;
      r_data    <= 4'h0;
      r_res     <= 8'h00;
      r_acc0    <= ACC_RESET;
      r_acc1    <= ACC_RESET;
      r_result0 <= 8'h00;
      r_result1 <= 8'h00;
      r_ack0    <= 1'b0;
      r_ack1    <= 1'b0;
      r_grant   <= 2'b00;
      r_rr_last <= 1'b1;
    end else begin
      r_ack0 <= 1'b0;
      r_ack1 <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_issue) begin
            // Op is captured here; later changes on func/data are ignored.
            r_owner <= w_winner;
            r_func  <= w_winner ? func1 : func0;
            r_data  <= w_winner ? data1 : data0;
            r_grant <= w_winner ? 2'b10 : 2'b01;
            r_cnt   <= c_CNT_LOAD;
          end
        end
        ST_EXEC: begin
          if (r_cnt != 4'd0) begin
            r_cnt <= r_cnt - 4'd1;
          end else begin
            r_res <= w_alu_res;
          end
        end
        ST_DONE: begin
          if (r_owner) begin
            r_acc1    <= r_res;
            r_result1 <= r_res;
            r_ack1    <= 1'b1;
          end else begin
            r_acc0    <= r_res;
            r_result0 <= r_res;
            r_ack0    <= 1'b1;
          end
          r_rr_last <= r_owner;
          r_grant   <= 2'b00;
        end
        default: begin
        end
      endcase
    end
  end

  assign ack0    = r_ack0;
  assign ack1    = r_ack1;
  assign result0 = r_result0;
  assign result1 = r_result1;
  assign acc0    = r_acc0;
  assign acc1    = r_acc1;
  assign grant   = r_grant;
  assign busy    = (r_state == ST_EXEC) || (r_state == ST_DONE);

endmodule
`default_nettype wire

// File: tb/tb_alu_share_scheduler.sv
`default_nettype none
// ============================================================================
// Module      : tb_alu_share_scheduler
// Description : Scoreboard bench for alu_share_scheduler. Drivers push the
//               expected result of every issued op into a per-requester
//               queue; a monitor pops and compares on each ack.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_alu_share_scheduler;

  localparam int unsigned EXEC_CYCLES = 2;
  localparam logic [7:0]  ACC_RESET   = 8'h00;

  logic       clock = 1'b0;
  logic       reset;
  logic       req0, req1;
  logic [2:0] func0, func1;
  logic [3:0] data0, data1;
  logic       ack0, ack1;
  logic [7:0] result0, result1, acc0, acc1;
  logic [1:0] grant;
  logic       busy;

  alu_share_scheduler #(
    .EXEC_CYCLES(EXEC_CYCLES),
    .ACC_RESET  (ACC_RESET)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .req0   (req0),
    .func0  (func0),
    .data0  (data0),
    .req1   (req1),
    .func1  (func1),
    .data1  (data1),
    .ack0   (ack0),
    .ack1   (ack1),
    .result0(result0),
    .result1(result1),
    .acc0   (acc0),
    .acc1   (acc1),
    .grant  (grant),
    .busy   (busy)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  bit sb_en  = 1'b1;

  logic [7:0] q0[$];
  logic [7:0] q1[$];
  logic [7:0] model_acc[2];
  logic [7:0] committed[2];

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference ALU written straight from the function table with integer math.
  function automatic logic [7:0] ref_alu(input logic [2:0] f, input logic [3:0] a4, input logic [3:0] b4);
    int a, b, r;
    a = int'(a4);
    b = int'(b4);
    r = 0;
    case (f)
      3'd0:       r = a + 1;
      3'd1, 3'd2: r = a + b;
      3'd3:       r = (a | b) * 16 + (a ^ b);
      3'd4:       r = (a != 0 || b != 0) ? 1 : 0;
      3'd5:       r = (a >= 8) ? 0 : ((b * (1 << a)) % 256);
      3'd6:       r = b / (1 << a);
      default:    r = a * b;
    endcase
    return 8'(r);
  endfunction

  task automatic drive(input int r, input logic rq, input logic [2:0] f, input logic [3:0] d);
    if (r == 0) begin
      req0 = rq; func0 = f; data0 = d;
    end else begin
      req1 = rq; func1 = f; data1 = d;
    end
  endtask

  function automatic logic ack_of(input int r);
    return (r == 0) ? ack0 : ack1;
  endfunction

  task automatic model_reset();
    model_acc[0] = ACC_RESET;
    model_acc[1] = ACC_RESET;
    committed[0] = ACC_RESET;
    committed[1] = ACC_RESET;
    q0.delete();
    q1.delete();
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1;
    drive(0, 1'b0, 3'd0, 4'd0);
    drive(1, 1'b0, 3'd0, 4'd0);
    repeat (2) @(negedge clock);
    model_reset();
    reset = 1'b0;
  endtask

  // Issue one op, scramble func/data once it is owned, drop req on ack.
  // lat = negedges from raising req until ack is observed.
  task automatic do_op(input int r, input logic [2:0] f, input logic [3:0] d, output int lat);
    logic [7:0] exp;
    int n, start;
    exp = ref_alu(f, d, model_acc[r][3:0]);
    model_acc[r] = exp;
    if (r == 0) q0.push_back(exp); else q1.push_back(exp);
    @(negedge clock);
    drive(r, 1'b1, f, d);
    start = cyc;
    n = 0;
    while (grant[r] !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) begin
      check("grant timeout", 32'(grant), 32'(r + 1));
    end else begin
      check("grant onehot", 32'(grant), (r == 0) ? 32'h1 : 32'h2);
    end
    drive(r, 1'b1, 3'($urandom), 4'($urandom));
    n = 0;
    while (ack_of(r) !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    if (n >= 100) check("ack timeout", 32'(ack_of(r)), 32'h1);
    drive(r, 1'b0, 3'd0, 4'd0);
    lat = cyc - start;
  endtask

  // Monitor: pops the scoreboard on every ack and checks global invariants.
  always @(negedge clock) begin
    if (reset === 1'b0) begin
      check("busy vs grant", {30'd0, busy, grant == 2'b11}, {30'd0, grant != 2'b00, 1'b0});
      if (ack0 && ack1) check("dual ack", 32'h3, 32'h0);
      if (ack0 === 1'b1) begin
        if (q0.size() == 0) begin
          if (sb_en) check("unexpected ack0", 32'h1, 32'h0);
        end else begin
          logic [7:0] e;
          e = q0.pop_front();
          check("sb result0", 32'(result0), 32'(e));
          check("sb acc0", 32'(acc0), 32'(e));
          check("sb acc1 untouched", 32'(acc1), 32'(committed[1]));
          committed[0] = e;
        end
      end
      if (ack1 === 1'b1) begin
        if (q1.size() == 0) begin
          if (sb_en) check("unexpected ack1", 32'h1, 32'h0);
        end else begin
          logic [7:0] e;
          e = q1.pop_front();
          check("sb result1", 32'(result1), 32'(e));
          check("sb acc1", 32'(acc1), 32'(e));
          check("sb acc0 untouched", 32'(acc0), 32'(committed[0]));
          committed[1] = e;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, n;
    logic [1:0] gseq[$];
    int aseq[$];
    logic [1:0] prev_g;

    reset = 1'b1;
    drive(0, 1'b0, 3'd0, 4'd0);
    drive(1, 1'b0, 3'd0, 4'd0);
    model_reset();
    do_reset();

    // Reset state
    check("rst ack", {30'd0, ack0, ack1}, 32'h0);
    check("rst result0", 32'(result0), 32'h0);
    check("rst result1", 32'(result1), 32'h0);
    check("rst acc0", 32'(acc0), 32'(ACC_RESET));
    check("rst acc1", 32'(acc1), 32'(ACC_RESET));
    check("rst grant", 32'(grant), 32'h0);
    check("rst busy", 32'(busy), 32'h0);

    // T1: increment; ack EXEC_CYCLES+1 edges after issue (+1 negedge of setup)
    do_op(0, 3'b000, 4'h7, lat);
    check("T1 latency", 32'(lat), 32'(EXEC_CYCLES + 2));
    check("T1 result0", 32'(result0), 32'h08);
    check("T1 acc0", 32'(acc0), 32'h08);
    check("T1 acc1", 32'(acc1), 32'h00);

    // T2: requester 1 add
    do_op(1, 3'b010, 4'h3, lat);
    check("T2 acc1", 32'(acc1), 32'h03);
    check("T2 result1", 32'(result1), 32'h03);
    check("T2 acc0", 32'(acc0), 32'h08);

    // T4: multiply then or/xor pack
    do_op(1, 3'b111, 4'hF, lat);
    check("T4 mul", 32'(acc1), 32'h2D);
    do_op(1, 3'b011, 4'hA, lat);
    check("T4 orxor", 32'(acc1), 32'hF7);

    // T5: shift boundaries
    do_op(0, 3'b000, 4'h0, lat);
    do_op(0, 3'b101, 4'h7, lat);
    check("T5 shl7", 32'(acc0), 32'h80);
    do_op(0, 3'b101, 4'h9, lat);
    check("T5 shl9", 32'(acc0), 32'h00);
    do_op(0, 3'b000, 4'h7, lat);
    do_op(0, 3'b110, 4'h3, lat);
    check("T5 shr3", 32'(acc0), 32'h01);
    do_op(0, 3'b101, 4'h8, lat);
    check("T5 shl8", 32'(acc0), 32'h00);
    do_op(0, 3'b100, 4'h0, lat);
    check("T5 orred zero", 32'(acc0), 32'h00);

    // T3: both held high -> strict alternation, back-to-back
    do_reset();
    sb_en = 1'b0;
    @(negedge clock);
    drive(0, 1'b1, 3'b000, 4'h1);
    drive(1, 1'b1, 3'b000, 4'h1);
    prev_g = 2'b00;
    n = 0;
    while ((aseq.size() < 4 || gseq.size() < 4) && n < 200) begin
      @(negedge clock);
      n++;
      if (grant != 2'b00 && grant != prev_g) gseq.push_back(grant);
      if (ack0) aseq.push_back(0);
      if (ack1) aseq.push_back(1);
      prev_g = grant;
    end
    drive(0, 1'b0, 3'd0, 4'd0);
    drive(1, 1'b0, 3'd0, 4'd0);
    check("T3 cycles", 32'(n < 200), 32'h1);
    check("T3 gseq size", 32'(gseq.size() >= 4), 32'h1);
    check("T3 aseq size", 32'(aseq.size() >= 4), 32'h1);
    if (gseq.size() >= 4 && aseq.size() >= 4) begin
      check("T3 grant seq", {24'd0, gseq[0], gseq[1], gseq[2], gseq[3]}, 32'h66);
      check("T3 ack seq", 32'(aseq[0] * 8 + aseq[1] * 4 + aseq[2] * 2 + aseq[3]), 32'h5);
    end
    repeat (6) @(negedge clock);
    do_reset();
    sb_en = 1'b1;

    // T6: reset mid-EXEC drops the op
    @(negedge clock);
    drive(0, 1'b1, 3'b000, 4'h5);
    n = 0;
    while (grant[0] !== 1'b1 && n < 100) begin
      @(negedge clock);
      n++;
    end
    check("T6 grant0", 32'(grant), 32'h1);
    drive(0, 1'b0, 3'b111, 4'hF);
    reset = 1'b1;
    @(negedge clock);
    check("T6 ack0", 32'(ack0), 32'h0);
    check("T6 acc0", 32'(acc0), 32'h00);
    check("T6 grant", 32'(grant), 32'h0);
    check("T6 busy", 32'(busy), 32'h0);
    model_reset();
    reset = 1'b0;
    n = 0;
    repeat (6) begin
      @(negedge clock);
      if (ack0) n++;
    end
    check("T6 no ack", 32'(n), 32'h0);
    do_op(0, 3'b000, 4'h5, lat);
    check("T6 latched data", 32'(acc0), 32'h06);

    // Random concurrent traffic
    fork
      begin
        int l0;
        for (int i = 0; i < 30; i++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          do_op(0, 3'($urandom), 4'($urandom), l0);
        end
      end
      begin
        int l1;
        for (int j = 0; j < 30; j++) begin
          repeat ($urandom_range(0, 3)) @(negedge clock);
          do_op(1, 3'($urandom), 4'($urandom), l1);
        end
      end
    join
    repeat (8) @(negedge clock);
    check("drain q0", 32'(q0.size()), 32'h0);
    check("drain q1", 32'(q1.size()), 32'h0);
    check("final acc0", 32'(acc0), 32'(model_acc[0]));
    check("final acc1", 32'(acc1), 32'(model_acc[1]));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
